// File: rtl/sreg_tx_arbiter_if.sv
// Handshake/bus bundle between the two parallel producers and the serial transmit arbiter.
interface sreg_tx_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             lsb_first;
    logic             abort;
    logic [1:0]       gnt;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic [1:0]       done;

    modport master (
        output req, data0, data1, lsb_first, abort,
        input  gnt, sout, sout_valid, busy, done
    );

    modport slave (
        input  req, data0, data1, lsb_first, abort,
        output gnt, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/sreg_tx_arbiter.sv
// Round-robin arbiter for two requesters sharing one WIDTH-bit serial shift register.
// Grants, loads the winner's word, shifts it out MSB- or LSB-first, pulses done per requester.
module sreg_tx_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    sreg_tx_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             ord;
    logic             last;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             sout_q;
    logic             valid_q;
    logic             busy_q;
    logic             win_c;

    // Contention goes to the requester not served last; a lone request always wins.
    assign win_c = (bus.req == 2'b11) ? ~last : bus.req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            ord     <= 1'b0;
            last    <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 2'b00;
                    if (bus.req != 2'b00) begin
                        state  <= SHIFT;
                        gnt_q  <= win_c ? 2'b10 : 2'b01;
                        busy_q <= 1'b1;
                        last   <= win_c;
                        shreg  <= win_c ? bus.data1 : bus.data0;
                        ord    <= bus.lsb_first;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        sout_q  <= 1'b0;
                        valid_q <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        sout_q  <= ord ? shreg[0] : shreg[WIDTH-1];
                        shreg   <= ord ? (shreg >> 1) : (shreg << 1);
                        valid_q <= 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // An abort here suppresses the completion pulse.
                    done_q  <= bus.abort ? 2'b00 : gnt_q;
                    state   <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    cnt     <= '0;
                end
                default: begin
                    state   <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 2'b00;
                    cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sreg_tx_arbiter.sv
// Bench for sreg_tx_arbiter: vector table, directed corner sequences, random run against a transfer-timeline model.
module tb_sreg_tx_arbiter;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sreg_tx_arbiter_if #(.WIDTH(WIDTH)) bus ();
    sreg_tx_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: each transfer is a timeline of edges t=0 (grant) .. WIDTH+1 (done pulse).
    logic             m_active = 1'b0;
    int               m_t = 0;
    logic             m_win = 1'b0;
    logic             m_last = 1'b1;
    logic [WIDTH-1:0] m_word = '0;
    logic             m_ord = 1'b0;
    logic [1:0]       e_gnt = 2'b00, e_done = 2'b00;
    logic             e_sout = 1'b0, e_valid = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        e_done = 2'b00;
        if (rst) begin
            m_active = 1'b0;
            m_last   = 1'b1;
        end else if (m_active && bus.abort) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t == WIDTH + 1) begin
                m_active = 1'b0;
                e_done   = 2'b01 << m_win;
            end
        end else if (bus.req != 2'b00) begin
            m_win    = (bus.req == 2'b11) ? !m_last : bus.req[1];
            m_last   = m_win;
            m_word   = m_win ? bus.data1 : bus.data0;
            m_ord    = bus.lsb_first;
            m_t      = 0;
            m_active = 1'b1;
        end
        e_gnt   = m_active ? (2'b01 << m_win) : 2'b00;
        e_busy  = m_active;
        e_valid = m_active && (m_t >= 1);
        e_sout  = e_valid ? (m_ord ? m_word[m_t-1] : m_word[WIDTH-m_t]) : 1'b0;
    end

    typedef struct {
        logic [1:0]       req;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic             lsb;
        logic [1:0]       exp_gnt;
        logic [WIDTH-1:0] exp_ser;   // serial bits in arrival order, first bit at MSB
    } vec_t;

    vec_t vecs[6];

    task automatic reset_dut();
        bus.req = 2'b00; bus.abort = 1'b0; bus.lsb_first = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        logic [WIDTH-1:0] col;
        int               nvalid;
        col = '0;
        nvalid = 0;
        bus.req = v.req; bus.data0 = v.d0; bus.data1 = v.d1; bus.lsb_first = v.lsb;
        tick();
        check($sformatf("v%0d_gnt", idx), bus.gnt, v.exp_gnt);
        check($sformatf("v%0d_busy", idx), bus.busy, 1);
        check($sformatf("v%0d_valid0", idx), bus.sout_valid, 0);
        for (int k = 0; k < int'(WIDTH); k++) begin
            tick();
            if (bus.sout_valid && bus.gnt == v.exp_gnt) nvalid++;
            col = {col[WIDTH-2:0], bus.sout};
        end
        check($sformatf("v%0d_validcnt", idx), nvalid, WIDTH);
        check($sformatf("v%0d_serial", idx), col, v.exp_ser);
        tick();
        check($sformatf("v%0d_done", idx), bus.done, v.exp_gnt);
        check($sformatf("v%0d_gnt_off", idx), {bus.gnt, bus.busy, bus.sout_valid}, 0);
        bus.req = 2'b00;
        tick();
        check($sformatf("v%0d_done_clr", idx), bus.done, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] col;
        logic [1:0]       prev, gval[4];
        int               gcyc[4];
        int               ng, both, bad;

        bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0; bus.lsb_first = 1'b0; bus.abort = 1'b0;

        vecs[0] = '{2'b01, 8'hA5, 8'h00, 1'b0, 2'b01, 8'hA5};
        vecs[1] = '{2'b10, 8'h00, 8'h0F, 1'b1, 2'b10, 8'hF0};
        vecs[2] = '{2'b11, 8'hFF, 8'h00, 1'b0, 2'b01, 8'hFF};
        vecs[3] = '{2'b11, 8'h3C, 8'h96, 1'b1, 2'b10, 8'h69};
        vecs[4] = '{2'b11, 8'h12, 8'h33, 1'b1, 2'b01, 8'h48};
        vecs[5] = '{2'b01, 8'h80, 8'hFF, 1'b0, 2'b01, 8'h80};

        reset_dut();
        check("reset_outs", {bus.gnt, bus.done, bus.sout, bus.sout_valid, bus.busy}, 0);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], i);

        // Contention: req=11 held from reset, alternating grants every WIDTH+2 cycles.
        reset_dut();
        bus.data0 = 8'hFF; bus.data1 = 8'h00; bus.lsb_first = 1'b0; bus.req = 2'b11;
        prev = 2'b00; ng = 0; both = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin gval[i] = 2'b00; gcyc[i] = 0; end
        for (int c = 0; c < 32; c++) begin
            tick();
            if (bus.gnt == 2'b11) both++;
            if (bus.gnt != 2'b00 && prev == 2'b00 && ng < 4) begin
                gval[ng] = bus.gnt; gcyc[ng] = c; ng++;
            end
            if (bus.sout_valid && ng > 0 && bus.sout != (gval[ng-1] == 2'b01)) bad++;
            prev = bus.gnt;
        end
        check("cont_grant0", gval[0], 2'b01);
        check("cont_grant1", gval[1], 2'b10);
        check("cont_grant2", gval[2], 2'b01);
        check("cont_gap01", gcyc[1] - gcyc[0], WIDTH + 2);
        check("cont_gap12", gcyc[2] - gcyc[1], WIDTH + 2);
        check("cont_onehot", both, 0);
        check("cont_bits", bad, 0);

        // Sampling: data and req change right after the grant edge.
        reset_dut();
        bus.req = 2'b01; bus.data0 = 8'hA5; bus.lsb_first = 1'b0;
        tick();
        bus.data0 = 8'h00; bus.req = 2'b00; bus.lsb_first = 1'b1;
        col = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            tick();
            col = {col[WIDTH-2:0], bus.sout};
        end
        check("samp_serial", col, 8'hA5);
        tick();
        check("samp_done", bus.done, 2'b01);

        // Abort after the 3rd valid bit; next grant goes to the other requester.
        reset_dut();
        bus.req = 2'b11; bus.data0 = 8'hFF; bus.data1 = 8'h00; bus.lsb_first = 1'b0;
        tick();
        check("abort_gnt0", bus.gnt, 2'b01);
        for (int k = 0; k < 3; k++) tick();
        check("abort_valid3", bus.sout_valid, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_outs", {bus.gnt, bus.sout_valid, bus.sout, bus.busy, bus.done}, 0);
        tick();
        check("abort_regnt", bus.gnt, 2'b10);
        check("abort_nodone", bus.done, 0);

        // Reset during the 5th valid bit restores last=1.
        reset_dut();
        bus.req = 2'b01; bus.data0 = 8'hC3; bus.lsb_first = 1'b0;
        tick();
        bus.req = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        check("rstmid_valid5", bus.sout_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_outs", {bus.gnt, bus.done, bus.sout, bus.sout_valid, bus.busy}, 0);
        tick();
        check("rstmid_regnt", bus.gnt, 2'b01);

        // Random traffic against the model.
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 2'($urandom_range(0, 3));
            bus.data0     = WIDTH'($urandom);
            bus.data1     = WIDTH'($urandom);
            bus.lsb_first = 1'($urandom_range(0, 1));
            bus.abort     = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
            check($sformatf("rand_c%0d", c),
                  {bus.gnt, bus.done, bus.sout, bus.sout_valid, bus.busy},
                  {e_gnt, e_done, e_sout, e_valid, e_busy});
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sreg_tx_arbiter.md
# sreg_tx_arbiter

Two-requester serial transmit controller for a WIDTH-bit shift register. Each requester presents a parallel word. The block grants the shared shift register round-robin, loads the granted word, shifts it out one bit per clock (MSB-first or LSB-first), and signals completion per requester. It sits between parallel producers and the single serial link driven by the SISO shift-register datapath.

## Interface
- WIDTH, 8, shift-register / word width in bits (≥2)
- clk  input  1  clock, rising-edge
- rst  input  1  reset, synchronous, active-high
- req  input  2  per-requester transfer request, level; hold until own done bit
- data0  input  WIDTH  word of requester 0, sampled only at grant edge
- data1  input  WIDTH  word of requester 1, sampled only at grant edge
- lsb_first  input  1  bit order, sampled at grant edge (0 = MSB first)
- abort  input  1  synchronous cancel of the current transfer
- gnt  output  2  one-hot grant, registered, high for whole transfer
- sout  output  1  serial data, registered
- sout_valid  output  1  sout carries a payload bit this cycle
- busy  output  1  state ≠ IDLE
- done  output  2  one-cycle completion pulse, one-hot to the served requester

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If req ≠ 0, the next edge selects a winner, sets gnt, loads shreg ← selected data, latches lsb_first into ord, clears cnt and enters SHIFT.
  - If req = 0, stay in IDLE.
- Arbitration:
  - `last` holds the index of the last granted requester; its reset value is 1.
  - With a single request, that requester wins.
  - With both requesting, grant !last.
  - `last` updates at each grant.
- SHIFT, each edge:
  - sout ← shreg[WIDTH-1] (ord=0) or shreg[0] (ord=1).
  - shreg shifts toward that end, zero-filled.
  - sout_valid ← 1 and cnt ← cnt+1.
  - When cnt == WIDTH-1 at the edge, go to DONE.
- DONE, one edge:
  - sout_valid ← 0, sout ← 0.
  - done ← gnt, then gnt ← 0.
  - Go to IDLE.
- IDLE also clears done on the next edge.
- Width and counter rules:
  - cnt is clog2(WIDTH) bits wide and never wraps past WIDTH-1.
  - The shift register is exactly WIDTH bits with no sign extension.
- req dropping during SHIFT is ignored and the transfer completes.
- Changes on data/lsb_first after the grant edge have no effect.
- abort:
  - In SHIFT or DONE, the next edge goes to IDLE with gnt=0, sout=0, sout_valid=0 and no done pulse; `last` keeps the aborted requester.
  - In IDLE, abort is ignored. An abort at the same edge as a grant does not block the grant.
- rst has priority over everything. At any point, including mid-transfer, the next edge sets state=IDLE, gnt=0, sout=0, sout_valid=0, done=0, busy=0, cnt=0, shreg=0, last=1.

## Timing
- E0 is the grant edge.
- gnt and busy are high from after E0 to after E(WIDTH+1), i.e. WIDTH+1 cycles.
- sout_valid is high from after E1 through after E(WIDTH), exactly WIDTH consecutive cycles. The first payload bit appears after E1.
- done pulses for the single cycle after E(WIDTH+1), with busy=0 in that cycle.
- The earliest next grant is E(WIDTH+2). Back-to-back period is WIDTH+2 cycles, and sout_valid has a 2-cycle gap between transfers.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single transfer:
  - Stimulus: WIDTH=8, rst 2 cycles, then req=01, data0=8'hA5, lsb_first=0.
  - Response: gnt=01 for 9 cycles; sout over 8 valid cycles = 1,0,1,0,0,1,0,1; done=01 one cycle after the last valid bit.
- LSB-first:
  - Stimulus: req=10, data1=8'h81→8'h0F, lsb_first=1.
  - Response: sout = 1,1,1,1,0,0,0,0; done=10.
- Contention / round-robin:
  - Stimulus: req=11 held immediately after reset, data0=8'hFF, data1=8'h00.
  - Response: grants in order 01, 10, 01, each separated by 10 cycles; sout all-1s then all-0s; never two gnt bits at once.
- Sampling:
  - Stimulus: change data0 from 8'hA5 to 8'h00 and drop req one cycle after grant.
  - Response: full 8'hA5 sequence still shifted and done=01 asserted.
- Abort:
  - Stimulus: assert abort for 1 cycle after the 3rd valid bit.
  - Response: next cycle gnt=0, sout_valid=0, no done pulse. With req=11 still held, the next grant goes to the other requester.
- Reset mid-transfer:
  - Stimulus: rst pulse during the 5th valid bit.
  - Response: all outputs 0 the next cycle. A following req=11 grants requester 0 first.
